// File: rtl/jelly_rtos_extflg_capture_if.sv
// ---------------------------------------------------------------------------
// jelly_rtos_extflg_capture_if
//   Bundles the event-line inputs, configuration and flag-set outputs of the
//   external event-flag input conditioner.
//   master : the environment (drives raw events and configuration)
//   slave  : the conditioner (drives flag-set pulses and filtered levels)
// Signals:
//   in_event       raw asynchronous event lines
//   debounce_len   required consecutive stable samples (quasi-static)
//   rise_en        per-bit rising-edge flag enable
//   fall_en        per-bit falling-edge flag enable
//   extflg_flgptn  registered one-cycle flag-set pulses to the RTOS
//   monitor_level  current filtered level per bit
// ---------------------------------------------------------------------------
interface jelly_rtos_extflg_capture_if #(
  parameter int FLGPTN_WIDTH   = 32,
  parameter int DEBOUNCE_WIDTH = 8
);
  logic [FLGPTN_WIDTH-1:0]   in_event;
  logic [DEBOUNCE_WIDTH-1:0] debounce_len;
  logic [FLGPTN_WIDTH-1:0]   rise_en;
  logic [FLGPTN_WIDTH-1:0]   fall_en;
  logic [FLGPTN_WIDTH-1:0]   extflg_flgptn;
  logic [FLGPTN_WIDTH-1:0]   monitor_level;

  modport master (
    output in_event,
    output debounce_len,
    output rise_en,
    output fall_en,
    input  extflg_flgptn,
    input  monitor_level
  );

  modport slave (
    input  in_event,
    input  debounce_len,
    input  rise_en,
    input  fall_en,
    output extflg_flgptn,
    output monitor_level
  );
endinterface

// File: rtl/jelly_rtos_extflg_capture.sv
// ---------------------------------------------------------------------------
// jelly_rtos_extflg_capture
//   Input conditioner in front of the RTOS external event-flag input. Each
//   event line is synchronized, debounced and edge-detected independently,
//   producing single-cycle flag-set pulses on qualified edges.
// Ports:
//   clk      single clock, shared with the RTOS core
//   reset_n  asynchronous active-low reset
//   cke      clock enable; all state holds while low
//   bus      slave side of jelly_rtos_extflg_capture_if (events, config,
//            flag-set pulses, filtered levels)
// Parameters:
//   FLGPTN_WIDTH    number of event lines
//   SYNC_STAGES     synchronizer depth, 2..4
//   DEBOUNCE_WIDTH  width of each stability counter and of debounce_len
//   INIT_LEVEL      reset value of synchronizer and filtered level per bit
// ---------------------------------------------------------------------------
module jelly_rtos_extflg_capture #(
  parameter int                      FLGPTN_WIDTH   = 32,
  parameter int                      SYNC_STAGES    = 2,
  parameter int                      DEBOUNCE_WIDTH = 8,
  parameter logic [FLGPTN_WIDTH-1:0] INIT_LEVEL     = '0
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic                            cke,
  jelly_rtos_extflg_capture_if.slave      bus
);

  localparam logic [DEBOUNCE_WIDTH-1:0] CNT_ZERO = {DEBOUNCE_WIDTH{1'b0}};
  localparam logic [DEBOUNCE_WIDTH-1:0] CNT_ONE  = {{(DEBOUNCE_WIDTH-1){1'b0}}, 1'b1};

  logic [FLGPTN_WIDTH-1:0]   sync_q [SYNC_STAGES];
  logic [FLGPTN_WIDTH-1:0]   sync_s;
  logic [DEBOUNCE_WIDTH-1:0] thresh_s;
  logic [DEBOUNCE_WIDTH-1:0] cnt_q  [FLGPTN_WIDTH];
  logic [DEBOUNCE_WIDTH-1:0] cnt_d  [FLGPTN_WIDTH];
  logic [FLGPTN_WIDTH-1:0]   level_q;
  logic [FLGPTN_WIDTH-1:0]   level_d;
  logic [FLGPTN_WIDTH-1:0]   level_dly_q;
  logic [FLGPTN_WIDTH-1:0]   flg_q;
  logic [FLGPTN_WIDTH-1:0]   flg_d;

  assign sync_s = sync_q[SYNC_STAGES-1];

  // Synchronizer shift chain per bit; the last stage feeds the debouncer.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        sync_q[s] <= INIT_LEVEL;
      end
    end else if (cke) begin
      sync_q[0] <= bus.in_event;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        sync_q[s] <= sync_q[s-1];
      end
    end
  end

  // Count threshold: N=0 is treated as N=1, i.e. the level may move on the
  // first mismatching sample.
  always_comb begin
    thresh_s = CNT_ZERO;
    if (bus.debounce_len == CNT_ZERO) begin
      thresh_s = CNT_ZERO;
    end else begin
      thresh_s = bus.debounce_len - CNT_ONE;
    end
  end

  // Debounce next-state per bit. The >= compare keeps the counter bounded
  // even if debounce_len is lowered below the current count.
  always_comb begin
    level_d = level_q;
    cnt_d   = cnt_q;
    for (int i = 0; i < FLGPTN_WIDTH; i++) begin
      if (sync_s[i] == level_q[i]) begin
        cnt_d[i]   = CNT_ZERO;
        level_d[i] = level_q[i];
      end else if (cnt_q[i] >= thresh_s) begin
        cnt_d[i]   = CNT_ZERO;
        level_d[i] = sync_s[i];
      end else begin
        cnt_d[i]   = cnt_q[i] + CNT_ONE;
        level_d[i] = level_q[i];
      end
    end
  end

  // Edge detect on the registered level against its one-edge-old copy, so
  // the pulse appears one edge after monitor_level changes. Because the
  // delayed copy is reset alongside the level, no pulse follows reset.
  always_comb begin
    flg_d = (level_q & ~level_dly_q & bus.rise_en)
          | (~level_q & level_dly_q & bus.fall_en);
  end

  // Debounce state, filtered level and flag-set pulse registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < FLGPTN_WIDTH; i++) begin
        cnt_q[i] <= CNT_ZERO;
      end
      level_q     <= INIT_LEVEL;
      level_dly_q <= INIT_LEVEL;
      flg_q       <= {FLGPTN_WIDTH{1'b0}};
    end else if (cke) begin
      cnt_q       <= cnt_d;
      level_q     <= level_d;
      level_dly_q <= level_q;
      flg_q       <= flg_d;
    end
  end

  assign bus.extflg_flgptn = flg_q;
  assign bus.monitor_level = level_q;

endmodule

// File: tb/tb_jelly_rtos_extflg_capture.sv
// ---------------------------------------------------------------------------
// tb_jelly_rtos_extflg_capture
//   Directed self-checking bench for jelly_rtos_extflg_capture with default
//   parameters (32 lines, 2 sync stages, 8-bit counters, INIT_LEVEL=0).
//   Inputs change 1 time unit after a rising edge; outputs are sampled at the
//   same point, so after k ticks the DUT has seen k edges with new inputs.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_jelly_rtos_extflg_capture;

  logic clk;
  logic reset_n;
  logic cke;
  int   n_tests;
  int   n_fail;

  jelly_rtos_extflg_capture_if #(.FLGPTN_WIDTH(32), .DEBOUNCE_WIDTH(8)) bus ();

  jelly_rtos_extflg_capture dut (
    .clk     (clk),
    .reset_n (reset_n),
    .cke     (cke),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    reset_n = 1'b0;
    cke     = 1'b1;
    bus.in_event = 32'h0;
    bus.rise_en  = 32'h0;
    bus.fall_en  = 32'h0;
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  task automatic test_reset;
    logic [31:0] exp;
    reset_n = 1'b0;
    cke = 1'b1;
    bus.in_event = 32'h0000_0001;
    bus.debounce_len = 8'd1;
    bus.rise_en = 32'h0;
    bus.fall_en = 32'h0;
    tick();
    tick();
    n_tests++;
    if (bus.extflg_flgptn !== 32'h0) begin
      n_fail++; $display("FAIL reset_flg got %h exp %h", bus.extflg_flgptn, 32'h0);
    end
    n_tests++;
    if (bus.monitor_level !== 32'h0) begin
      n_fail++; $display("FAIL reset_level got %h exp %h", bus.monitor_level, 32'h0);
    end
    reset_n = 1'b1;
    for (int t = 1; t <= 6; t++) begin
      tick();
      n_tests++;
      if (bus.extflg_flgptn !== 32'h0) begin
        n_fail++; $display("FAIL release_norise t=%0d got %h exp %h", t, bus.extflg_flgptn, 32'h0);
      end
      exp = (t >= 3) ? 32'h1 : 32'h0;
      n_tests++;
      if (bus.monitor_level !== exp) begin
        n_fail++; $display("FAIL release_level t=%0d got %h exp %h", t, bus.monitor_level, exp);
      end
    end
    reset_n = 1'b0;
    tick();
    bus.rise_en = 32'h0000_0001;
    reset_n = 1'b1;
    for (int t = 1; t <= 6; t++) begin
      tick();
      exp = (t == 4) ? 32'h1 : 32'h0;
      n_tests++;
      if (bus.extflg_flgptn !== exp) begin
        n_fail++; $display("FAIL release_rise t=%0d got %h exp %h", t, bus.extflg_flgptn, exp);
      end
    end
  endtask

  task automatic test_single_rise;
    logic [31:0] exp;
    do_reset();
    bus.debounce_len = 8'd1;
    bus.rise_en = 32'hFFFF_FFFF;
    bus.in_event = 32'h0000_0008;
    for (int t = 1; t <= 6; t++) begin
      tick();
      exp = (t == 4) ? 32'h0000_0008 : 32'h0;
      n_tests++;
      if (bus.extflg_flgptn !== exp) begin
        n_fail++; $display("FAIL single_rise t=%0d got %h exp %h", t, bus.extflg_flgptn, exp);
      end
      exp = (t >= 3) ? 32'h0000_0008 : 32'h0;
      n_tests++;
      if (bus.monitor_level !== exp) begin
        n_fail++; $display("FAIL single_level t=%0d got %h exp %h", t, bus.monitor_level, exp);
      end
    end
  endtask

  task automatic test_glitch;
    logic [31:0] exp;
    do_reset();
    bus.debounce_len = 8'd5;
    bus.rise_en = 32'hFFFF_FFFF;
    bus.in_event = 32'h1;
    for (int t = 1; t <= 12; t++) begin
      if (t == 5) bus.in_event = 32'h0;
      tick();
      n_tests++;
      if (bus.extflg_flgptn !== 32'h0) begin
        n_fail++; $display("FAIL glitch_flg t=%0d got %h exp %h", t, bus.extflg_flgptn, 32'h0);
      end
      n_tests++;
      if (bus.monitor_level !== 32'h0) begin
        n_fail++; $display("FAIL glitch_level t=%0d got %h exp %h", t, bus.monitor_level, 32'h0);
      end
    end
    bus.in_event = 32'h1;
    for (int t = 1; t <= 10; t++) begin
      if (t == 7) bus.in_event = 32'h0;
      tick();
      exp = (t == 8) ? 32'h1 : 32'h0;
      n_tests++;
      if (bus.extflg_flgptn !== exp) begin
        n_fail++; $display("FAIL debounce5 t=%0d got %h exp %h", t, bus.extflg_flgptn, exp);
      end
    end
  endtask

  task automatic test_fall_only;
    logic [31:0] exp;
    do_reset();
    bus.debounce_len = 8'd3;
    bus.rise_en = 32'h0;
    bus.fall_en = 32'h0000_0080;
    bus.in_event = 32'h0000_0080;
    for (int t = 1; t <= 40; t++) begin
      if (t == 21) bus.in_event = 32'h0;
      tick();
      exp = (t == 26) ? 32'h0000_0080 : 32'h0;
      n_tests++;
      if (bus.extflg_flgptn !== exp) begin
        n_fail++; $display("FAIL fall_only t=%0d got %h exp %h", t, bus.extflg_flgptn, exp);
      end
    end
  endtask

  task automatic test_both_edges;
    logic [31:0] exp;
    do_reset();
    bus.debounce_len = 8'd2;
    bus.rise_en = 32'h0000_0020;
    bus.fall_en = 32'h0000_0020;
    bus.in_event = 32'h0000_0020;
    for (int t = 1; t <= 20; t++) begin
      if (t == 11) bus.in_event = 32'h0;
      tick();
      exp = (t == 5 || t == 15) ? 32'h0000_0020 : 32'h0;
      n_tests++;
      if (bus.extflg_flgptn !== exp) begin
        n_fail++; $display("FAIL both_edges t=%0d got %h exp %h", t, bus.extflg_flgptn, exp);
      end
    end
  endtask

  task automatic test_multi_cke;
    logic [31:0] exp;
    do_reset();
    bus.debounce_len = 8'd1;
    bus.rise_en = 32'hFFFF_FFFF;
    bus.in_event = 32'h8000_8001;
    for (int t = 1; t <= 6; t++) begin
      tick();
      exp = (t == 4) ? 32'h8000_8001 : 32'h0;
      n_tests++;
      if (bus.extflg_flgptn !== exp) begin
        n_fail++; $display("FAIL multi_bit t=%0d got %h exp %h", t, bus.extflg_flgptn, exp);
      end
    end
    // Mid-debounce stall on edges 4..6, then a stall while the pulse is up.
    do_reset();
    bus.debounce_len = 8'd3;
    bus.rise_en = 32'hFFFF_FFFF;
    bus.in_event = 32'h1;
    for (int t = 1; t <= 13; t++) begin
      cke = ((t >= 4 && t <= 6) || t == 10 || t == 11) ? 1'b0 : 1'b1;
      tick();
      exp = (t >= 9 && t <= 11) ? 32'h1 : 32'h0;
      n_tests++;
      if (bus.extflg_flgptn !== exp) begin
        n_fail++; $display("FAIL cke_stall t=%0d got %h exp %h", t, bus.extflg_flgptn, exp);
      end
    end
    cke = 1'b1;
  endtask

  task automatic test_reset_mid;
    logic [31:0] exp;
    do_reset();
    bus.debounce_len = 8'd10;
    bus.rise_en = 32'hFFFF_FFFF;
    bus.in_event = 32'h2;
    for (int t = 1; t <= 8; t++) begin
      tick();
    end
    reset_n = 1'b0;
    #1;
    n_tests++;
    if (bus.extflg_flgptn !== 32'h0) begin
      n_fail++; $display("FAIL midreset_flg got %h exp %h", bus.extflg_flgptn, 32'h0);
    end
    tick();
    n_tests++;
    if (bus.extflg_flgptn !== 32'h0) begin
      n_fail++; $display("FAIL midreset_hold got %h exp %h", bus.extflg_flgptn, 32'h0);
    end
    reset_n = 1'b1;
    for (int t = 1; t <= 15; t++) begin
      tick();
      exp = (t == 13) ? 32'h2 : 32'h0;
      n_tests++;
      if (bus.extflg_flgptn !== exp) begin
        n_fail++; $display("FAIL midreset_lat t=%0d got %h exp %h", t, bus.extflg_flgptn, exp);
      end
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    reset_n = 1'b0;
    cke     = 1'b1;
    bus.in_event     = 32'h0;
    bus.debounce_len = 8'd1;
    bus.rise_en      = 32'h0;
    bus.fall_en      = 32'h0;
    test_reset();
    test_single_rise();
    test_glitch();
    test_fall_only();
    test_both_edges();
    test_multi_cke();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
